// File: rtl/pipeline_bus_ctrl_pkg.sv
// Shared definitions for the pipeline bus controller: FSM state type,
// bus-owner output encodings and the stolen-cycle counter limit.
package pipeline_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2
  } bus_state_t;

  // Output triple driven for each bus owner.
  typedef struct packed {
    logic bus_request;
    logic fetch_suppress;
    logic mem_ack;
  } bus_owner_t;

  localparam bus_owner_t OWNER_FETCH = '{bus_request: 1'b0, fetch_suppress: 1'b0, mem_ack: 1'b0};
  localparam bus_owner_t OWNER_DATA  = '{bus_request: 1'b1, fetch_suppress: 1'b1, mem_ack: 1'b1};
  localparam bus_owner_t OWNER_FLUSH = '{bus_request: 1'b0, fetch_suppress: 1'b1, mem_ack: 1'b0};

  localparam logic [15:0] STATS_MAX = 16'hFFFF;

  // Map a state onto its output encoding; unknown states fall back to the
  // safe fetch encoding so (1,0) on bus_request/fetch_suppress never appears.
  function automatic bus_owner_t owner_of(input bus_state_t s);
    bus_owner_t o;
    case (s)
      ST_FETCH: o = OWNER_FETCH;
      ST_DATA:  o = OWNER_DATA;
      ST_FLUSH: o = OWNER_FLUSH;
      default:  o = OWNER_FETCH;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pipeline_cycle_counter.sv
// Loadable down-counter used for both the flush length and the burst limit.
// o_last flags the final cycle of the loaded run (count of one or less, so a
// counter that is somehow at zero still lets its owner leave the state).
module pipeline_cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic             o_last
);

  logic [WIDTH-1:0] r_count;

  // Count register: load beats clear beats decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_clr) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_dec && (r_count != {WIDTH{1'b0}})) begin
      r_count <= r_count - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_last = (r_count <= {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pipeline_bus_ctrl.sv
// Pipeline bus controller: arbitrates the shared memory bus between the
// instruction fetch stage and later data accesses, injects NOP cycles after
// taken branches and tracks the PC/RA role swap flag.
// Optional feature: define PIPELINE_BUS_STATS_EN to add the 16-bit saturating
// stolen_cycles output (counts DATA and FLUSH cycles).
module pipeline_bus_ctrl
  import pipeline_bus_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_BURST    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        flush,
  input  logic        pcra_swap,
  output logic        bus_request,
  output logic        fetch_suppress,
  output logic        mem_ack,
  output logic        flag_pcraflip
`ifdef PIPELINE_BUS_STATS_EN
  ,
  output logic [15:0] stolen_cycles
`endif
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [3:0] BURST_LOAD = 4'(MAX_BURST);

  bus_state_t r_state;
  bus_state_t w_next;
  bus_owner_t w_owner;

  logic r_bus_request;
  logic r_fetch_suppress;
  logic r_mem_ack;
  logic r_flag_pcraflip;

  logic w_flush_load, w_flush_dec, w_flush_clr, w_flush_last;
  logic w_burst_load, w_burst_dec, w_burst_clr, w_burst_last;

  // Flush counter: holds the NOP cycles remaining, including the current one.
  pipeline_cycle_counter #(.WIDTH(3)) u_flush_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_flush_load),
    .i_load_val (FLUSH_LOAD),
    .i_dec      (w_flush_dec),
    .i_clr      (w_flush_clr),
    .o_last     (w_flush_last)
  );

  // Burst counter: holds the data grants left in this burst, including the current one.
  pipeline_cycle_counter #(.WIDTH(4)) u_burst_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_burst_load),
    .i_load_val (BURST_LOAD),
    .i_dec      (w_burst_dec),
    .i_clr      (w_burst_clr),
    .o_last     (w_burst_last)
  );

  // Next-state selection: flush first, then an unfinished flush, then data requests.
  always_comb begin
    w_next = ST_FETCH;
    if (flush) begin
      w_next = ST_FLUSH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_req) w_next = ST_DATA;
          else         w_next = ST_FETCH;
        end
        ST_DATA: begin
          // The final grant of a burst always yields one cycle back to fetch.
          if (mem_req && !w_burst_last) w_next = ST_DATA;
          else                          w_next = ST_FETCH;
        end
        ST_FLUSH: begin
          if (!w_flush_last) w_next = ST_FLUSH;
          else if (mem_req)  w_next = ST_DATA;
          else               w_next = ST_FETCH;
        end
        default: w_next = ST_FETCH;
      endcase
    end
  end

  // A new flush always reloads; a burst loads only when DATA is freshly entered.
  assign w_flush_load = flush;
  assign w_flush_dec  = (r_state == ST_FLUSH) && (w_next == ST_FLUSH) && !flush;
  assign w_flush_clr  = (w_next != ST_FLUSH);
  assign w_burst_load = (w_next == ST_DATA) && (r_state != ST_DATA);
  assign w_burst_dec  = (w_next == ST_DATA) && (r_state == ST_DATA);
  assign w_burst_clr  = (w_next != ST_DATA);

  assign w_owner = owner_of(w_next);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  // Registered bus-owner outputs, taken from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_request    <= 1'b0;
      r_fetch_suppress <= 1'b0;
      r_mem_ack        <= 1'b0;
    end else begin
      r_bus_request    <= w_owner.bus_request;
      r_fetch_suppress <= w_owner.fetch_suppress;
      r_mem_ack        <= w_owner.mem_ack;
    end
  end

  // PC/RA role flag: flips after every swap pulse regardless of bus activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_flag_pcraflip <= 1'b0;
    else       r_flag_pcraflip <= r_flag_pcraflip ^ pcra_swap;
  end

  assign bus_request    = r_bus_request;
  assign fetch_suppress = r_fetch_suppress;
  assign mem_ack        = r_mem_ack;
  assign flag_pcraflip  = r_flag_pcraflip;

`ifdef PIPELINE_BUS_STATS_EN
  logic [15:0] r_stolen_cycles;

  // Saturating count of cycles the fetch stage lost the bus (DATA or FLUSH).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stolen_cycles <= 16'h0000;
    end else if ((r_state != ST_FETCH) && (r_stolen_cycles != STATS_MAX)) begin
      r_stolen_cycles <= r_stolen_cycles + 16'h0001;
    end else begin
      r_stolen_cycles <= r_stolen_cycles;
    end
  end

  assign stolen_cycles = r_stolen_cycles;
`endif

endmodule

// File: tb/tb_pipeline_bus_ctrl.sv
// Directed bench for pipeline_bus_ctrl with a cycle-level behavioural model
// of the bus-ownership rules and a per-cycle compare on the falling edge.
module tb_pipeline_bus_ctrl;

  localparam int FC = 2;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_req = 1'b0;
  logic flush = 1'b0;
  logic pcra_swap = 1'b0;
  logic bus_request, fetch_suppress, mem_ack, flag_pcraflip;
`ifdef PIPELINE_BUS_STATS_EN
  logic [15:0] stolen_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner 0=fetch 1=data 2=flush, run = consecutive data grants,
  // fl = flush cycles elapsed in the current flush episode.
  int   m_mode   = 0;
  int   m_run    = 0;
  int   m_fl     = 0;
  int   m_nxt    = 0;
  logic m_flag   = 1'b0;
  int   m_stolen = 0;

  logic [9:0] tr_dut;
  logic [9:0] tr_mod;
  int         acks;

  pipeline_bus_ctrl #(.FLUSH_CYCLES(FC), .MAX_BURST(MB)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .flush          (flush),
    .pcra_swap      (pcra_swap),
    .bus_request    (bus_request),
    .fetch_suppress (fetch_suppress),
    .mem_ack        (mem_ack),
    .flag_pcraflip  (flag_pcraflip)
`ifdef PIPELINE_BUS_STATS_EN
    ,
    .stolen_cycles  (stolen_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_zero();
    m_mode = 0; m_run = 0; m_fl = 0; m_flag = 1'b0; m_stolen = 0;
  endtask

  // Advance the model by one rising edge using the inputs that were sampled.
  task automatic model_update();
    if (reset) begin
      model_zero();
    end else begin
      if (m_mode != 0) m_stolen = (m_stolen < 65535) ? m_stolen + 1 : 65535;
      if (flush) begin
        m_nxt = 2; m_fl = 1;
      end else if (m_mode == 2 && m_fl < FC) begin
        m_nxt = 2; m_fl = m_fl + 1;
      end else if (mem_req && !(m_mode == 1 && m_run == MB)) begin
        m_nxt = 1;
        m_run = (m_mode == 1) ? m_run + 1 : 1;
      end else begin
        m_nxt = 0;
      end
      if (m_nxt != 1) m_run = 0;
      m_flag = m_flag ^ pcra_swap;
      m_mode = m_nxt;
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, update the model.
  task automatic step(input logic rq, input logic fl, input logic sw);
    mem_req = rq; flush = fl; pcra_swap = sw;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    chk("bus_request",    {31'd0, bus_request},    {31'd0, (m_mode == 1)});
    chk("fetch_suppress", {31'd0, fetch_suppress}, {31'd0, (m_mode != 0)});
    chk("mem_ack",        {31'd0, mem_ack},        {31'd0, (m_mode == 1)});
    chk("flag_pcraflip",  {31'd0, flag_pcraflip},  {31'd0, m_flag});
    chk("enc_1_0_never",  {31'd0, (bus_request & ~fetch_suppress)}, 32'd0);
`ifdef PIPELINE_BUS_STATS_EN
    chk("stolen_cycles",  {16'd0, stolen_cycles},  m_stolen);
`endif
  end

  initial begin
    // Reset held, then 5 idle cycles.
    step(1'b1, 1'b0, 1'b0);
    chk("rst_bus_request", {31'd0, bus_request}, 32'd0);
    chk("rst_fetch_suppress", {31'd0, fetch_suppress}, 32'd0);
    chk("rst_flag", {31'd0, flag_pcraflip}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (5) step(1'b0, 1'b0, 1'b0);
    chk("idle_fetch_suppress", {31'd0, fetch_suppress}, 32'd0);

    // Two-cycle request.
    tr_dut = '0; tr_mod = '0;
    for (int i = 0; i < 5; i++) begin
      step((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      tr_dut = {tr_dut[8:0], bus_request};
      tr_mod = {tr_mod[8:0], (m_mode == 1)};
    end
    chk("req2_trace_dut",   {22'd0, tr_dut}, 32'b00000_11000);
    chk("req2_trace_model", {22'd0, tr_mod}, 32'b00000_11000);

    // Ten-cycle request: burst limit forces one fetch cycle.
    tr_dut = '0; tr_mod = '0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      tr_dut = {tr_dut[8:0], bus_request};
      tr_mod = {tr_mod[8:0], (m_mode == 1)};
      if (mem_ack) acks++;
    end
    step(1'b0, 1'b0, 1'b0);
    chk("burst_trace_dut",   {22'd0, tr_dut}, 32'b11110_11110);
    chk("burst_trace_model", {22'd0, tr_mod}, 32'b11110_11110);
    chk("burst_ack_count", acks, 32'd8);
    step(1'b0, 1'b0, 1'b0);

    // Flush with request pending: two NOP cycles then data.
    tr_dut = '0; tr_mod = '0;
    step(1'b1, 1'b1, 1'b0);
    tr_dut = {tr_dut[7:0], bus_request, fetch_suppress};
    tr_mod = {tr_mod[7:0], (m_mode == 1), (m_mode != 0)};
    for (int i = 0; i < 3; i++) begin
      step((i < 2) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      tr_dut = {tr_dut[7:0], bus_request, fetch_suppress};
      tr_mod = {tr_mod[7:0], (m_mode == 1), (m_mode != 0)};
    end
    chk("flush_trace_dut",   {22'd0, tr_dut}, 32'b00_01_01_11_00);
    chk("flush_trace_model", {22'd0, tr_mod}, 32'b00_01_01_11_00);

    // Flush re-asserted on the first flush cycle restarts the count.
    tr_dut = '0; tr_mod = '0;
    for (int i = 0; i < 5; i++) begin
      step((i < 4) ? 1'b1 : 1'b0, (i < 2) ? 1'b1 : 1'b0, 1'b0);
      tr_dut = {tr_dut[7:0], bus_request, fetch_suppress};
      tr_mod = {tr_mod[7:0], (m_mode == 1), (m_mode != 0)};
    end
    chk("reflush_trace_dut",   {22'd0, tr_dut}, 32'b01_01_01_11_00);
    chk("reflush_trace_model", {22'd0, tr_mod}, 32'b01_01_01_11_00);

    // PC/RA swap during data, then together with a flush.
    tr_dut = '0; tr_mod = '0;
    step(1'b1, 1'b0, 1'b0);
    tr_dut = {tr_dut[8:0], flag_pcraflip};
    tr_mod = {tr_mod[8:0], m_flag};
    step(1'b1, 1'b0, 1'b1);
    tr_dut = {tr_dut[8:0], flag_pcraflip};
    tr_mod = {tr_mod[8:0], m_flag};
    chk("swap_in_data_bus_request", {31'd0, bus_request}, 32'd1);
    step(1'b1, 1'b1, 1'b1);
    tr_dut = {tr_dut[8:0], flag_pcraflip};
    tr_mod = {tr_mod[8:0], m_flag};
    chk("swap_flush_fetch_suppress", {31'd0, fetch_suppress}, 32'd1);
    chk("swap_flush_bus_request", {31'd0, bus_request}, 32'd0);
    chk("swap_trace_dut",   {22'd0, tr_dut}, 32'b010);
    chk("swap_trace_model", {22'd0, tr_mod}, 32'b010);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Reset asserted mid-burst, between clock edges.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    #1;
    reset = 1'b1;
    model_zero();
    #1;
    chk("midrst_bus_request", {31'd0, bus_request}, 32'd0);
    chk("midrst_fetch_suppress", {31'd0, fetch_suppress}, 32'd0);
    chk("midrst_mem_ack", {31'd0, mem_ack}, 32'd0);
    chk("midrst_flag", {31'd0, flag_pcraflip}, 32'd0);
`ifdef PIPELINE_BUS_STATS_EN
    chk("midrst_stolen", {16'd0, stolen_cycles}, 32'd0);
`endif
    step(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_fetch", {31'd0, bus_request}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("post_rst_data", {31'd0, mem_ack}, 32'd1);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
